// File: rtl/id_ex_pipe.sv
// ID/EX pipeline register with load-use hazard detection, stall/flush
// control and saturating bubble/flush event counters.
module id_ex_pipe #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [XLEN-1:0]  id_pc,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic [4:0]       id_rd,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic [XLEN-1:0]  id_rs1_data,
    input  logic [XLEN-1:0]  id_rs2_data,
    input  logic [XLEN-1:0]  id_imm,
    input  logic [3:0]       id_alu_op,
    input  logic             id_reg_write,
    input  logic             id_mem_read,
    input  logic             id_mem_write,
    input  logic             flush,
    input  logic             mem_busy,
    output logic             stall_id,
    output logic             ex_valid,
    output logic [XLEN-1:0]  ex_pc,
    output logic [XLEN-1:0]  ex_rs1_data,
    output logic [XLEN-1:0]  ex_rs2_data,
    output logic [XLEN-1:0]  ex_imm,
    output logic [4:0]       ex_rs1,
    output logic [4:0]       ex_rs2,
    output logic [4:0]       ex_rd,
    output logic [3:0]       ex_alu_op,
    output logic             ex_reg_write,
    output logic             ex_mem_read,
    output logic             ex_mem_write,
    output logic [CNT_W-1:0] bubble_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int unsigned REG_W = 5;
    localparam int unsigned OP_W  = 4;

    // Payload held in the EX slot; all-zero is a bubble.
    typedef struct packed {
        logic             valid;
        logic [XLEN-1:0]  pc;
        logic [XLEN-1:0]  rs1_data;
        logic [XLEN-1:0]  rs2_data;
        logic [XLEN-1:0]  imm;
        logic [REG_W-1:0] rs1;
        logic [REG_W-1:0] rs2;
        logic [REG_W-1:0] rd;
        logic [OP_W-1:0]  alu_op;
        logic             reg_write;
        logic             mem_read;
        logic             mem_write;
    } ex_slot_t;

    ex_slot_t ex_q;
    ex_slot_t id_slot;
    logic     hazard;
    logic     rs1_hit;
    logic     rs2_hit;

    // Pack decode inputs; control bits are qualified by id_valid.
    always_comb begin
        id_slot           = '0;
        id_slot.valid     = id_valid;
        id_slot.pc        = id_pc;
        id_slot.rs1_data  = id_rs1_data;
        id_slot.rs2_data  = id_rs2_data;
        id_slot.imm       = id_imm;
        id_slot.rs1       = id_rs1;
        id_slot.rs2       = id_rs2;
        id_slot.rd        = id_rd;
        id_slot.alu_op    = id_alu_op;
        id_slot.reg_write = id_reg_write & id_valid;
        id_slot.mem_read  = id_mem_read  & id_valid;
        id_slot.mem_write = id_mem_write & id_valid;
    end

    // Load-use detection against the load currently in EX; x0 never hazards.
    always_comb begin
        rs1_hit = id_uses_rs1 & (id_rs1 == ex_q.rd);
        rs2_hit = id_uses_rs2 & (id_rs2 == ex_q.rd);
        hazard  = ex_q.valid & ex_q.mem_read & (ex_q.rd != REG_W'(0))
                & id_valid & (rs1_hit | rs2_hit);
    end

    assign stall_id = (hazard & ~flush) | mem_busy;

    // EX slot and counters: reset > flush > mem_busy hold > hazard bubble > load.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q       <= '0;
            bubble_cnt <= '0;
            flush_cnt  <= '0;
        end else if (flush) begin
            ex_q <= '0;
            if (flush_cnt != {CNT_W{1'b1}}) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end
        end else if (mem_busy) begin
            ex_q <= ex_q;
        end else if (hazard) begin
            ex_q <= '0;
            if (bubble_cnt != {CNT_W{1'b1}}) begin
                bubble_cnt <= bubble_cnt + CNT_W'(1);
            end
        end else begin
            ex_q <= id_slot;
        end
    end

    assign ex_valid     = ex_q.valid;
    assign ex_pc        = ex_q.pc;
    assign ex_rs1_data  = ex_q.rs1_data;
    assign ex_rs2_data  = ex_q.rs2_data;
    assign ex_imm       = ex_q.imm;
    assign ex_rs1       = ex_q.rs1;
    assign ex_rs2       = ex_q.rs2;
    assign ex_rd        = ex_q.rd;
    assign ex_alu_op    = ex_q.alu_op;
    assign ex_reg_write = ex_q.reg_write;
    assign ex_mem_read  = ex_q.mem_read;
    assign ex_mem_write = ex_q.mem_write;

endmodule

// File: doc/id_ex_pipe.md
# id_ex_pipe

ID/EX pipeline register for the five-stage RISC-V core, with integrated load-use hazard detection and stall/flush control. It captures register-file read data, immediate, PC and decoded control from the decode stage. It presents them to the execute stage one cycle later. It also generates the decode/fetch stall that resolves load-use hazards, and keeps saturating counters of inserted bubbles and flushes for performance debug.

## Interface
Parameters
- XLEN, 32, datapath width
- CNT_W, 16, width of performance counters

Ports
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- id_valid  in  1  decode stage holds a real instruction
- id_pc  in  XLEN  PC of decode instruction
- id_rs1, id_rs2, id_rd  in  5  register indices
- id_uses_rs1, id_uses_rs2  in  1  instruction actually reads rs1/rs2
- id_rs1_data, id_rs2_data  in  XLEN  register-file read data (already WB-bypassed)
- id_imm  in  XLEN  decoded immediate
- id_alu_op  in  4  ALU operation code
- id_reg_write, id_mem_read, id_mem_write  in  1  control bits
- flush  in  1  branch/jump taken in EX; kill decode instruction
- mem_busy  in  1  memory stage not ready; freeze this register
- stall_id  out  1  hold IF and ID this cycle (combinational)
- ex_valid  out  1  EX slot holds a real instruction
- ex_pc, ex_rs1_data, ex_rs2_data, ex_imm  out  XLEN  registered copies
- ex_rs1, ex_rs2, ex_rd  out  5  registered indices
- ex_alu_op  out  4; ex_reg_write, ex_mem_read, ex_mem_write  out  1
- bubble_cnt, flush_cnt  out  CNT_W  saturating event counters

## Operation
- Hazard detect (combinational): hazard = ex_valid & ex_mem_read & (ex_rd != 0) & id_valid & ((id_uses_rs1 & id_rs1 == ex_rd) | (id_uses_rs2 & id_rs2 == ex_rd)).
- stall_id = (hazard & ~flush) | mem_busy.
- Register update, priority highest first:
  - rst: all outputs cleared to 0, including counters.
  - flush: load a bubble (ex_valid=0, ex_reg_write=ex_mem_read=ex_mem_write=0, other fields 0); flush_cnt += 1. Flush wins over mem_busy and hazard.
  - mem_busy: hold all registers unchanged.
  - hazard: load a bubble; bubble_cnt += 1.
  - otherwise: load all id_* fields. ex_valid = id_valid. Control bits are ANDed with id_valid, so an invalid ID never asserts writes.
- Bubble: data fields are zeroed, never left stale.
- Counters saturate at all-ones and do not wrap. They increment only on the events listed above.
- rd = x0 never triggers a hazard. uses_rsN = 0 masks the compare for that operand.

## Timing
- Latency: one cycle, ID inputs at edge N appear on ex_* after edge N.
- Load-use costs exactly one bubble. After the bubble, ex_mem_read = 0, so the hazard deasserts and the held ID instruction loads on the next edge.
- stall_id has no registered delay. It is valid in the same cycle as its inputs.
- Reset mid-stall: on the reset edge all state clears. stall_id then depends only on mem_busy, because ex_valid = 0.
- Simultaneous flush and hazard: flush takes priority. stall_id is 0 from the hazard term, and flush_cnt increments while bubble_cnt does not.
- Simultaneous flush and mem_busy: bubble is loaded. stall_id = 1 because of mem_busy.

## Test plan
- Reset: assert rst for 2 cycles with random inputs -> all ex_* = 0, ex_valid = 0, counters = 0, stall_id = mem_busy.
- Pass-through: id_valid=1, pc=0x100, rs1_data=0xDEADBEEF, imm=0x14, reg_write=1 -> next cycle ex_pc=0x100, ex_rs1_data=0xDEADBEEF, ex_imm=0x14, ex_reg_write=1, ex_valid=1.
- Load-use: EX holds lw with rd=x5, ID has add using rs2=x5 -> stall_id=1 for exactly 1 cycle, one bubble in EX, bubble_cnt=1, and the add appears on ex_* one cycle later.
- No false hazard:
  - EX lw rd=x0 with ID rs1=x0 -> stall_id=0.
  - EX lw rd=x5 with ID using x5 only as rs2, id_uses_rs2=0 -> stall_id=0.
  - EX add (not a load) rd=x5 -> stall_id=0.
- Flush vs hazard vs mem_busy:
  - flush together with hazard -> bubble loaded, flush_cnt=1, bubble_cnt=0, stall_id=0.
  - mem_busy for 3 cycles -> ex_* unchanged, stall_id=1 for those cycles.
- Saturation: force 2^CNT_W+5 flushes -> flush_cnt holds 0xFFFF and does not wrap.
